// File: rtl/alu_issue_stage.sv
// ALU issue register: forwards operands from MEM/WB and registers them with op/mod for the ALU.
// Latency 1 cycle; in_ready drops on a full output slot without out_ready, or on a load-use hazard (bubble).
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_a_sel,
  input  logic              in_b_sel,
  input  logic [2:0]        in_op,
  input  logic              in_mod,
  input  logic              in_reg_write,
  input  logic              in_is_load,
  input  logic [4:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_value,
  input  logic [4:0]        wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [XLEN-1:0]   out_store_data,
  output logic [XLEN-1:0]   out_pc,
  output logic [2:0]        out_op,
  output logic              out_mod,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic              out_is_load,
  output logic [CNT_W-1:0]  stall_count
);

  logic              out_valid_q,      out_valid_d;
  logic [XLEN-1:0]   out_a_q,          out_a_d;
  logic [XLEN-1:0]   out_b_q,          out_b_d;
  logic [XLEN-1:0]   out_store_data_q, out_store_data_d;
  logic [XLEN-1:0]   out_pc_q,         out_pc_d;
  logic [2:0]        out_op_q,         out_op_d;
  logic              out_mod_q,        out_mod_d;
  logic [4:0]        out_rd_q,         out_rd_d;
  logic              out_reg_write_q,  out_reg_write_d;
  logic              out_is_load_q,    out_is_load_d;
  logic [CNT_W-1:0]  stall_count_q,    stall_count_d;

  logic              hazard;
  logic              capture;
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;

  // A load in MEM has no data yet, so it is never a bypass source; MEM beats WB otherwise.
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_val,
    input logic [4:0]      m_rd,
    input logic            m_we,
    input logic            m_ld,
    input logic [XLEN-1:0] m_val,
    input logic [4:0]      w_rd,
    input logic            w_we,
    input logic [XLEN-1:0] w_val
  );
    if (rs == 5'd0)                      return '0;
    else if (m_we && !m_ld && m_rd == rs) return m_val;
    else if (w_we && w_rd == rs)          return w_val;
    else                                  return rf_val;
  endfunction

  always_comb begin
    rs1_fwd = fwd(in_rs1, in_rs1_val, mem_rd, mem_reg_write, mem_is_load, mem_value,
                  wb_rd, wb_reg_write, wb_value);
    rs2_fwd = fwd(in_rs2, in_rs2_val, mem_rd, mem_reg_write, mem_is_load, mem_value,
                  wb_rd, wb_reg_write, wb_value);
  end

  // rs1 only matters when it feeds operand a; rs2 always matters because of store data.
  assign hazard = in_valid && mem_reg_write && mem_is_load && (mem_rd != 5'd0) &&
                  (((mem_rd == in_rs1) && !in_a_sel) || (mem_rd == in_rs2));

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign capture  = in_valid && in_ready;

  always_comb begin
    out_valid_d      = out_valid_q;
    out_a_d          = out_a_q;
    out_b_d          = out_b_q;
    out_store_data_d = out_store_data_q;
    out_pc_d         = out_pc_q;
    out_op_d         = out_op_q;
    out_mod_d        = out_mod_q;
    out_rd_d         = out_rd_q;
    out_reg_write_d  = out_reg_write_q;
    out_is_load_d    = out_is_load_q;
    stall_count_d    = stall_count_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d      = 1'b1;
      out_a_d          = in_a_sel ? in_pc : rs1_fwd;
      out_b_d          = in_b_sel ? in_imm : rs2_fwd;
      out_store_data_d = rs2_fwd;
      out_pc_d         = in_pc;
      out_op_d         = in_op;
      out_mod_d        = in_mod;
      out_rd_d         = in_rd;
      out_reg_write_d  = in_reg_write;
      out_is_load_d    = in_is_load;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (hazard && !flush && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q      <= 1'b0;
      out_a_q          <= '0;
      out_b_q          <= '0;
      out_store_data_q <= '0;
      out_pc_q         <= '0;
      out_op_q         <= '0;
      out_mod_q        <= 1'b0;
      out_rd_q         <= '0;
      out_reg_write_q  <= 1'b0;
      out_is_load_q    <= 1'b0;
      stall_count_q    <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_a_q          <= out_a_d;
      out_b_q          <= out_b_d;
      out_store_data_q <= out_store_data_d;
      out_pc_q         <= out_pc_d;
      out_op_q         <= out_op_d;
      out_mod_q        <= out_mod_d;
      out_rd_q         <= out_rd_d;
      out_reg_write_q  <= out_reg_write_d;
      out_is_load_q    <= out_is_load_d;
      stall_count_q    <= stall_count_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_a          = out_a_q;
  assign out_b          = out_b_q;
  assign out_store_data = out_store_data_q;
  assign out_pc         = out_pc_q;
  assign out_op         = out_op_q;
  assign out_mod        = out_mod_q;
  assign out_rd         = out_rd_q;
  assign out_reg_write  = out_reg_write_q;
  assign out_is_load    = out_is_load_q;
  assign stall_count    = stall_count_q;

endmodule
